// File: rtl/adder_pkg.sv
// adder_pkg: defaults, slice-width helper and geometry check shared by pipelined_adder.
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV
`define ADDER_SLICE_W(w, s) ((w) / (s))
package adder_pkg;
  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_STAGES = 4;
  function automatic logic geometry_ok(input int w, input int s);
    return s >= 1 && s <= w && w % s == 0;
  endfunction
endpackage
`endif

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit add with carry-in; also reports the carry into its MSB.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);
  logic [W:0] t;
  assign t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign s = t[W-1:0];
  assign co = t[W];
  assign c_msb = a[W-1] ^ b[W-1] ^ s[W-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep WIDTH-bit adder, carry ripples one slice per clock.
// Define ADDER_SUBTRACT_EN to add the sub port (sum = a-b when sub=1).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SLICE_W = `ADDER_SLICE_W(WIDTH, STAGES);
  logic adv;
  logic ovf_d;
  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipelined_adder: STAGES must be in 1..WIDTH and divide WIDTH");
  end
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  // Stage k owns its input skew registers (slices k..STAGES-1 of a/b) and its output registers.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [(STAGES-k)*SLICE_W-1:0] opa;
    logic [(STAGES-k)*SLICE_W-1:0] opb;
    logic [(k+1)*SLICE_W-1:0]      sn;
    logic [(k+1)*SLICE_W-1:0]      s_q;
    logic [SLICE_W-1:0]            bs;
    logic [SLICE_W-1:0]            ps;
    logic                          ci;
    logic                          co;
    logic                          vi;
    logic                          c_q;
    logic                          v_q;
`ifdef ADDER_SUBTRACT_EN
    logic sb;
    assign bs = sb ? ~opb[SLICE_W-1:0] : opb[SLICE_W-1:0];
`else
    assign bs = opb[SLICE_W-1:0];
`endif
    if (k == 0) begin : g_head
      assign opa = a;
      assign opb = b;
      assign vi = in_valid;
      assign sn = ps;
`ifdef ADDER_SUBTRACT_EN
      assign sb = sub;
      assign ci = sub | cin;
`else
      assign ci = cin;
`endif
    end else begin : g_body
      assign vi = g_stg[k-1].v_q;
      assign ci = g_stg[k-1].c_q;
      assign sn = {ps, g_stg[k-1].s_q};
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          opa <= '0;
          opb <= '0;
        end else if (adv) begin
          opa <= g_stg[k-1].opa[(STAGES-k+1)*SLICE_W-1:SLICE_W];
          opb <= g_stg[k-1].opb[(STAGES-k+1)*SLICE_W-1:SLICE_W];
        end
`ifdef ADDER_SUBTRACT_EN
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
          sb <= 1'b0;
        else if (adv)
          sb <= g_stg[k-1].sb;
`endif
    end
    if (k == STAGES-1) begin : g_top
      logic c_msb;
      adder_slice #(.W(SLICE_W)) u_slice (
        .a    (opa[SLICE_W-1:0]),
        .b    (bs),
        .ci   (ci),
        .s    (ps),
        .co   (co),
        .c_msb(c_msb)
      );
      assign ovf_d = c_msb ^ co;
    end else begin : g_low
      logic c_msb_unused;
      adder_slice #(.W(SLICE_W)) u_slice (
        .a    (opa[SLICE_W-1:0]),
        .b    (bs),
        .ci   (ci),
        .s    (ps),
        .co   (co),
        .c_msb(c_msb_unused)
      );
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        s_q <= sn;
        c_q <= co;
        v_q <= vi;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      ovf <= 1'b0;
    else if (adv)
      ovf <= ovf_d;
  assign sum = g_stg[STAGES-1].s_q;
  assign cout = g_stg[STAGES-1].c_q;
  assign out_valid = g_stg[STAGES-1].v_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder at WIDTH=16, STAGES=4.
// Subtract vectors run only when ADDER_SUBTRACT_EN is defined.
module tb_pipelined_adder;
  typedef struct {
    logic [17:0] v;
    int          f;
  } ent_t;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic cin = 0;
  logic out_ready = 1;
  logic in_ready, out_valid, cout, ovf;
  logic [15:0] a = 0;
  logic [15:0] b = 0;
  logic [15:0] sum;
`ifdef ADDER_SUBTRACT_EN
  logic sub = 0;
`endif
  ent_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic check_lat = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef ADDER_SUBTRACT_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask
  // Expected value e is {ovf, cout, sum}, computed by hand.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s,
                      input logic [17:0] e);
    int n = 0;
    ent_t t;
    @(negedge clk);
    a = x;
    b = y;
    cin = c;
    in_valid = 1;
`ifdef ADDER_SUBTRACT_EN
    sub = s;
`endif
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (in_ready) begin
      t.v = e;
      t.f = cyc;
      exp_q.push_back(t);
    end else begin
      checks++;
      errors++;
      $display("FAIL send: in_ready stuck low");
    end
  endtask
  task automatic stop_in();
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask
  initial begin : monitor
    ent_t t;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected output: sum=%h cout=%b with empty scoreboard", sum, cout);
        end else begin
          t = exp_q.pop_front();
          chk("result", {14'b0, ovf, cout, sum}, {14'b0, t.v});
          if (check_lat) chk("latency", cyc - t.f, 4);
        end
      end
    end
  end
  initial begin
    a = 16'h1234;
    b = 16'h1111;
    in_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    chk("reset ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1;
    in_valid = 0;
    #1;
    chk("in_ready after reset", in_ready, 1);
    check_lat = 1;
    send(16'h0003, 16'h0004, 0, 0, {2'b00, 16'h0007});
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 0;
      #1;
      chk("first out_valid timing", out_valid, (i == 4) ? 1 : 0);
    end
    drain();
    send(16'h1234, 16'h1111, 0, 0, {2'b00, 16'h2345});
    send(16'hFFFF, 16'h0001, 0, 0, {2'b01, 16'h0000});
    stop_in();
    drain();
    send(16'h7FFF, 16'h0001, 0, 0, {2'b10, 16'h8000});
    send(16'h8000, 16'h8000, 0, 0, {2'b11, 16'h0000});
    stop_in();
    drain();
    check_lat = 0;
    send(16'h0001, 16'h0002, 1, 0, {2'b00, 16'h0004});
    send(16'h00FF, 16'h0001, 0, 0, {2'b00, 16'h0100});
    send(16'h0FFF, 16'h0001, 0, 0, {2'b00, 16'h1000});
    send(16'hABCD, 16'h1234, 0, 0, {2'b00, 16'hBE01});
    send(16'hFFFF, 16'hFFFF, 1, 0, {2'b01, 16'hFFFF});
    send(16'h4000, 16'h4000, 0, 0, {2'b10, 16'h8000});
    @(negedge clk);
    in_valid = 0;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall in_ready", in_ready, 0);
      chk("stall out_valid", out_valid, 1);
      if (exp_q.size() != 0) chk("stall sum held", sum, exp_q[0].v[15:0]);
      @(negedge clk);
    end
    out_ready = 1;
    drain();
    send(16'h1111, 16'h2222, 0, 0, {2'b00, 16'h3333});
    send(16'h0100, 16'h0200, 0, 0, {2'b00, 16'h0300});
    send(16'h0010, 16'h0020, 0, 0, {2'b00, 16'h0030});
    stop_in();
    @(negedge clk);
    #1;
    chk("pre-reset out_valid", out_valid, 1);
    #1;
    rst_n = 0;
    exp_q.delete();
    #1;
    chk("mid-reset out_valid", out_valid, 0);
    chk("mid-reset sum", sum, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("no stale output", out_valid, 0);
    end
`ifdef ADDER_SUBTRACT_EN
    check_lat = 1;
    send(16'h0005, 16'h0007, 1, 1, {2'b00, 16'hFFFE});
    send(16'h0007, 16'h0005, 0, 1, {2'b01, 16'h0002});
    send(16'h0007, 16'h0005, 0, 0, {2'b00, 16'h000C});
    stop_in();
    drain();
`endif
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined WIDTH-bit adder with carry-in/carry-out and a valid/ready handshake on both sides.
- Successor to the team's single-bit full adder: the operand is split into STAGES equal slices and the carry ripples one slice per clock, so long words close timing.
- Sits between operand-producing logic (counters, accumulators, DSP front-ends) and a downstream consumer that may back-pressure.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES
STAGES, 4, pipeline stages = slices; latency in cycles; 1..WIDTH
SLICE_W, WIDTH/STAGES, derived local constant; bits added per stage

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  a, b, cin valid this cycle
in_ready  output  1  adder accepts operands this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
cin  input  1  carry into bit 0
sub  input  1  subtract request; present only with ADDER_SUBTRACT_EN
out_valid  output  1  sum and cout valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  a+b+cin mod 2^WIDTH (or a-b, see feature)
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits, sum, cout and ovf are cleared to 0, so out_valid=0. in_ready=1 while rst_n=1 and the pipe is empty. Reset mid-operation discards all in-flight results; no partial output is produced.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv. It is combinational from out_ready and has no dependence on in_valid.
- Stalls are global: when adv=0, every stage register holds, including valid bits and partial sums.
- Bubbles are not compressed. A result is accepted only when adv=1, whatever the state of earlier stages.
- Transfer: the input fires when in_valid & in_ready; the output fires when out_valid & out_ready.
- Stage k (0..STAGES-1):
  - Adds slice k of a and b (bits k*SLICE_W+:SLICE_W) plus the carry registered by stage k-1; stage 0 uses cin.
  - Registers the SLICE_W-bit partial sum, its carry, and the valid bit.
  - Not-yet-added upper slices of a and b travel with the data in skew registers.
  - Lower partial sums travel forward in de-skew registers.
- Latency: exactly STAGES cycles from input fire to out_valid when there is no back-pressure. Throughput is 1 result per cycle.
- Arithmetic:
  - sum = (a+b+cin)[WIDTH-1:0]; cout = bit WIDTH of the full sum.
  - ovf is computed in the last stage from the carry into the MSB and cout.
  - Wrap-around: 0xFFFF+0x0001 gives sum=0x0000, cout=1.
- Simultaneous input fire and output fire in the same cycle: both happen. The pipe stays full and the ordering is preserved.
- in_valid=1 with in_ready=0: operands must be held stable by the producer. The adder does not sample them.
- STAGES=1 degenerates to one registered adder with latency 1.
- Outputs are registered and hold their value while out_valid & !out_ready.

Optional Feature:
- Macro: ADDER_SUBTRACT_EN.
- Defined:
  - Port sub exists and is sampled with a and b at input fire.
  - When sub=1, stage 0 uses ~b and carry-in 1, ignoring cin, so sum = a-b mod 2^WIDTH and cout=1 means no borrow.
  - sub travels down the pipe with each operand.
- Undefined: the sub port and its logic are absent; the block is an adder only.

Decomposition:
- Shared package/include (adder_pkg):
  - Default WIDTH/STAGES constants.
  - SLICE_W derivation macro.
  - The WIDTH % STAGES == 0 elaboration check.
- One natural sub-module: adder_slice.
  - Combinational SLICE_W-bit add with carry-in, producing sum, carry-out and the carry into its MSB.
  - Instantiated STAGES times by generate.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0. Deassert rst_n -> first out_valid exactly 4 cycles after the first fire.
2. Streaming: WIDTH=16, STAGES=4, out_ready=1; apply 0x1234+0x1111, cin=0, then 0xFFFF+0x0001, cin=0, back to back.
   - Expected: 0x2345/cout 0 on cycle 4, then 0x0000/cout 1 on cycle 5.
   - The second result checks the carry rippling across all four slices.
3. Back-pressure: fill the pipe with 6 operands, then drop out_ready for 5 cycles -> in_ready=0 and sum held stable. Raise out_ready -> all 6 results emerge in order with no loss or duplication.
4. Overflow: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0. 0x8000+0x8000 -> sum=0x0000, ovf=1, cout=1.
5. Mid-operation reset: assert rst_n low while 3 results are in flight -> out_valid=0 immediately, and no stale result appears after release.
6. With ADDER_SUBTRACT_EN: 0x0005-0x0007 -> sum=0xFFFE, cout=0. 0x0007-0x0005 -> sum=0x0002, cout=1.
